// File: rtl/dram_cache_pkg.sv
// Shared constants, bundle types and helpers for the DRAM cache tag-check path.
// The typedefs describe the default configuration (64-bit address, 56-bit tag).
package dram_cache_pkg;

  localparam int ADDR_W   = 64;
  localparam int ID_W     = 16;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  // One way of set metadata as delivered by the memory controller.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } meta_way_t;

  // One pending request held in the queue.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic              write;
  } tag_req_t;

  // One resolved hit/miss result; the way field is wide enough for 16 ways.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic              hit;
    logic [3:0]        way;
    logic              victim_dirty;
    logic              multi_hit;
  } tag_res_t;

  // Width of a way index; a direct-mapped cache still gets a 1-bit field.
  function automatic int way_w(input int num_ways);
    return (num_ways <= 1) ? 1 : $clog2(num_ways);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dram_cache_sync_fifo.sv
// Synchronous FIFO with occupancy count, used as the pending-request queue.
// A push while full is refused even if a pop happens in the same cycle.
module dram_cache_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; entries beyond the count are never observed.
  // NOTE: the data array has no reset -- validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_cache_tag_check.sv
// N-way tag check: queues requests, pairs each in order with a metadata beat,
// and registers one hit/miss result per request on a valid/ready channel.
// Optional hit/miss statistics counters: define DRAM_CACHE_TAG_STATS_EN.
module dram_cache_tag_check
  import dram_cache_pkg::*;
#(
  parameter  int ADDR_WIDTH   = ADDR_W,
  parameter  int ID_WIDTH     = ID_W,
  parameter  int INDEX_WIDTH  = INDEX_W,
  parameter  int OFFSET_WIDTH = OFFSET_W,
  parameter  int NUM_WAYS     = 4,
  parameter  int QUEUE_DEPTH  = 8,
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int WAY_W        = way_w(NUM_WAYS),
  localparam int META_W       = TAG_WIDTH + 2,
  localparam int CNT_W        = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ID_WIDTH-1:0]        req_id_i,
  input  logic [ADDR_WIDTH-1:0]      req_addr_i,
  input  logic                       req_write_i,
  input  logic                       meta_valid_i,
  output logic                       meta_ready_o,
  input  logic [NUM_WAYS*META_W-1:0] meta_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [ID_WIDTH-1:0]        res_id_o,
  output logic [ADDR_WIDTH-1:0]      res_addr_o,
  output logic                       res_write_o,
  output logic                       res_hit_o,
  output logic [WAY_W-1:0]           res_way_o,
  output logic                       res_victim_dirty_o,
  output logic                       res_multi_hit_o,
`ifdef DRAM_CACHE_TAG_STATS_EN
  input  logic                       stat_clr_i,
  output logic [31:0]                stat_rd_hit_o,
  output logic [31:0]                stat_rd_miss_o,
  output logic [31:0]                stat_wr_hit_o,
  output logic [31:0]                stat_wr_miss_o,
`endif
  output logic [CNT_W-1:0]           q_count_o
);

  localparam int REQ_W = ID_WIDTH + ADDR_WIDTH + 1;
  localparam int MC_W  = $clog2(NUM_WAYS + 1);

  logic [REQ_W-1:0]      head;
  logic                  q_full;
  logic                  q_empty;
  logic                  meta_fire;
  logic [ID_WIDTH-1:0]   head_id;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  head_write;
  logic [TAG_WIDTH-1:0]  req_tag;

  logic [NUM_WAYS-1:0]   way_valid;
  logic [NUM_WAYS-1:0]   way_dirty;
  logic [NUM_WAYS-1:0]   match;
  logic [MC_W-1:0]       match_cnt;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      inv_way;
  logic                  any_inv;
  logic                  hit;
  logic [WAY_W-1:0]      victim_way;
  logic                  victim_dirty;
  logic [WAY_W-1:0]      rr_ptr;

  dram_cache_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_pending_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid_i && req_ready_o),
    .push_data ({req_id_i, req_addr_i, req_write_i}),
    .pop       (meta_fire),
    .pop_data  (head),
    .count     (q_count_o),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign req_ready_o  = !q_full;
  assign meta_ready_o = !q_empty && (!res_valid_o || res_ready_i);
  assign meta_fire    = meta_valid_i && meta_ready_o;

  assign head_id    = head[REQ_W-1 -: ID_WIDTH];
  assign head_addr  = head[ADDR_WIDTH:1];
  assign head_write = head[0];
  assign req_tag    = head_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  // Per-way decode, lowest-index match/invalid priority and match count.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    way_valid = '0;
    way_dirty = '0;
    match     = '0;
    match_cnt = '0;
    hit_way   = '0;
    inv_way   = '0;
    any_inv   = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      way_valid[w] = meta_i[w*META_W + TAG_WIDTH + 1];
      way_dirty[w] = meta_i[w*META_W + TAG_WIDTH];
      match[w]     = way_valid[w] && (meta_i[w*META_W +: TAG_WIDTH] == req_tag);
      if (match[w]) begin
        hit_way   = WAY_W'(w);
        match_cnt = match_cnt + MC_W'(1);
      end
      if (!way_valid[w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign hit          = |match;
  assign victim_way   = any_inv ? inv_way : rr_ptr;
  assign victim_dirty = way_valid[victim_way] && way_dirty[victim_way];

  // Round-robin victim pointer: moves only on a miss into a fully valid set.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (meta_fire && !hit && !any_inv) begin
      rr_ptr <= (NUM_WAYS == 1) ? '0 : rr_ptr + WAY_W'(1);
    end
  end

  // Result register: load on meta handshake, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_o        <= 1'b0;
      res_id_o           <= '0;
      res_addr_o         <= '0;
      res_write_o        <= 1'b0;
      res_hit_o          <= 1'b0;
      res_way_o          <= '0;
      res_victim_dirty_o <= 1'b0;
      res_multi_hit_o    <= 1'b0;
    end else if (meta_fire) begin
      res_valid_o        <= 1'b1;
      res_id_o           <= head_id;
      res_addr_o         <= head_addr;
      res_write_o        <= head_write;
      res_hit_o          <= hit;
      res_way_o          <= hit ? hit_way : victim_way;
      res_victim_dirty_o <= !hit && victim_dirty;
      res_multi_hit_o    <= (match_cnt > MC_W'(1));
    end else if (res_ready_i) begin
      res_valid_o        <= 1'b0;
    end
  end

`ifdef DRAM_CACHE_TAG_STATS_EN
  // Saturating hit/miss counters by type, bumped on result acceptance.
  always_ff @(posedge clk) begin
    if (rst || stat_clr_i) begin
      stat_rd_hit_o  <= '0;
      stat_rd_miss_o <= '0;
      stat_wr_hit_o  <= '0;
      stat_wr_miss_o <= '0;
    end else if (res_valid_o && res_ready_i) begin
      case ({res_write_o, res_hit_o})
        2'b01:   stat_rd_hit_o  <= sat_inc(stat_rd_hit_o);
        2'b00:   stat_rd_miss_o <= sat_inc(stat_rd_miss_o);
        2'b11:   stat_wr_hit_o  <= sat_inc(stat_wr_hit_o);
        default: stat_wr_miss_o <= sat_inc(stat_wr_miss_o);
      endcase
    end
  end
`endif

endmodule
